keyboard_keymap: RTL
====================

KEYBOARD_KEYMAP -- requirements
Module: keyboard_keymap

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of tracked keys (1..16).
REQ-002 SHALL have parameter KEY_CODES, default {9'h01B,9'h01D,9'h172,9'h175}, packed 9 bits per key: key i = KEY_CODES[9*i +: 9], bit 8 = E0-extended, bits 7:0 = make code.
REQ-003 SHALL have parameter FILTER_LEN, default 8, consecutive equal samples required to accept a PS/2 line level change.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, idle clocks allowed between PS/2 clock falling edges mid-frame.
REQ-005 SHALL have port keyboard_keymap_clk  input  1  system clock (100 MHz).
REQ-006 SHALL have port keyboard_keymap_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port keyboard_keymap_kclk  input  1  raw PS2_CLK.
REQ-008 SHALL have port keyboard_keymap_kdata  input  1  raw PS2_DATA.
REQ-009 SHALL have port keyboard_keymap_held  output  NUM_KEYS  level per key, 1 = held.
REQ-010 SHALL have port keyboard_keymap_press  output  NUM_KEYS  one-cycle pulse per key on press.
REQ-011 SHALL have port keyboard_keymap_release  output  NUM_KEYS  one-cycle pulse per key on release.
REQ-012 SHALL have port keyboard_keymap_byte  output  8  last good received byte.
REQ-013 SHALL have port keyboard_keymap_byte_vld  output  1  one-cycle strobe, byte updated.
REQ-014 SHALL have port keyboard_keymap_err  output  1  one-cycle pulse on frame error or timeout.

Function
REQ-015 SHALL synchronise kclk/kdata through 2 flops, then filter each: filtered level changes only after FILTER_LEN identical consecutive samples.
REQ-016 SHALL act only on filtered kclk falling edges, detected in the clock cycle the filtered level goes 1->0 (the "edge cycle"); fully synchronous, no derived clocks.
REQ-017 Frame FSM SHALL have states IDLE, DATA, PARITY, STOP: IDLE samples start bit (must be 0), DATA shifts 8 bits LSB first, PARITY samples parity, STOP samples stop (must be 1), then IDLE.
REQ-018 Start bit 1 SHALL stay in IDLE without error; stop bit 0 SHALL pulse err and discard the byte.
REQ-019 In DATA/PARITY/STOP, TIMEOUT_CYCLES clocks without an edge SHALL pulse err, return to IDLE, discard partial byte.
REQ-020 A good frame SHALL update byte and pulse byte_vld one cycle after the STOP edge cycle.
REQ-021 Decode FSM SHALL have states BASE, EXT, BRK, EXT_BRK: E0 in BASE->EXT; F0 in BASE->BRK, in EXT->EXT_BRK; any other byte is a code, decoded with ext = (state is EXT or EXT_BRK), brk = (state is BRK or EXT_BRK), then ->BASE.
REQ-022 Bytes AA, FA, FE, EE, E1 SHALL be ignored and return the decode FSM to BASE.
REQ-023 A code matching key i ({ext,code} == KEY_CODES[9*i +: 9]) SHALL, two cycles after the STOP edge cycle, set held[i] and pulse press[i] on make, or clear held[i] and pulse release[i] on break.
REQ-024 Make while held[i]=1 (typematic repeat) SHALL not pulse press[i]; break while held[i]=0 SHALL not pulse release[i].
REQ-025 Duplicate entries in KEY_CODES SHALL all update together; unmatched codes SHALL change no outputs except byte/byte_vld.
REQ-026 Any err SHALL also force the decode FSM to BASE; held SHALL be unaffected.
REQ-027 Multiple keys SHALL be held independently (any subset of NUM_KEYS).

Reset
REQ-028 Assertion SHALL immediately force held, press, release, byte, byte_vld, err to 0, both FSMs to IDLE/BASE, filtered levels to 1, timeout counter to 0, including mid-frame.
REQ-029 First edge after deassertion SHALL be treated as a start bit; a frame interrupted by reset is lost silently.

Configuration
REQ-030 With KEYBOARD_KEYMAP_PARITY_EN defined, parity SHALL be checked as odd over data+parity; mismatch pulses err and discards the byte.
REQ-031 Without KEYBOARD_KEYMAP_PARITY_EN, the parity bit SHALL be sampled and ignored; no parity checker logic synthesised.

Verification
REQ-032 Frames 0xE0,0x75 -> held=4'b0001, press=4'b0001 one cycle; then 0xE0,0xF0,0x75 -> held=4'b0000, release=4'b0001.
REQ-033 0x1D, 0x1D, 0x1D (typematic) -> exactly one press[2] pulse, held[2]=1; then 0xF0,0x1D -> release[2], held[2]=0.
REQ-034 0x1D then 0x1B held together, then 0xF0,0x1D -> held=4'b1000.
REQ-035 With PARITY_EN, 0x1D sent with even parity -> err pulse, held unchanged, no byte_vld; without macro -> held[2]=1.
REQ-036 Stop after 5 data bits for >TIMEOUT_CYCLES -> err pulse; next clean 0x1B frame -> held[3]=1.
REQ-037 rst_n low mid-frame after 0xE0 received -> all outputs 0 at once; after release, 0x75 alone -> no key change (FSM in BASE, code 0x075 unmapped).

Source files
------------

// File: rtl/keyboard_keymap.sv
// PS/2 keyboard receiver that tracks the held/press/release state of a fixed set of keys.
// Optional odd-parity checking is enabled by defining KEYBOARD_KEYMAP_PARITY_EN.
module keyboard_keymap #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h01B, 9'h01D, 9'h172, 9'h175},
  parameter int                    FILTER_LEN     = 8,
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                keyboard_keymap_clk,
  input  logic                keyboard_keymap_rst_n,
  input  logic                keyboard_keymap_kclk,
  input  logic                keyboard_keymap_kdata,
  output logic [NUM_KEYS-1:0] keyboard_keymap_held,
  output logic [NUM_KEYS-1:0] keyboard_keymap_press,
  output logic [NUM_KEYS-1:0] keyboard_keymap_release,
  output logic [7:0]          keyboard_keymap_byte,
  output logic                keyboard_keymap_byte_vld,
  output logic                keyboard_keymap_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk;
  logic rst_n;
  assign clk   = keyboard_keymap_clk;
  assign rst_n = keyboard_keymap_rst_n;

  // Stage 0/1: two-flop synchronisers; then per-line glitch filter (bit 0 = kclk, bit 1 = kdata)
  logic [1:0]     sync_p0;
  logic [1:0]     sync_p1;
  logic [1:0]     filt;
  logic [FCW-1:0] fcnt [2];
  logic           kclk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
      filt    <= '1;
      kclk_d  <= 1'b1;
      for (int j = 0; j < 2; j++) fcnt[j] <= '0;
    end else begin
      sync_p0 <= {keyboard_keymap_kdata, keyboard_keymap_kclk};
      sync_p1 <= sync_p0;
      kclk_d  <= filt[0];
      for (int j = 0; j < 2; j++) begin
        if (sync_p1[j] == filt[j]) begin
          fcnt[j] <= '0;
        end else if (fcnt[j] == FCW'(FILTER_LEN - 1)) begin
          filt[j] <= sync_p1[j];
          fcnt[j] <= '0;
        end else begin
          fcnt[j] <= fcnt[j] + FCW'(1);
        end
      end
    end
  end

  logic fall;
  logic dbit;
  assign fall = kclk_d & ~filt[0];
  assign dbit = filt[1];

  // Frame FSM: start / 8 data LSB-first / parity / stop, with inter-edge timeout
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_t;
  frame_t         frame_state, frame_next;
  logic [2:0]     bit_cnt, bit_cnt_n;
  logic [7:0]     shift, shift_n;
  logic [TCW-1:0] tcnt, tcnt_n;
  logic           good, ferr, par_ok;
  logic [7:0]     byte_q;
  logic           byte_vld_q;
  logic           err_q;

`ifdef KEYBOARD_KEYMAP_PARITY_EN
  logic par_bit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                par_bit <= 1'b0;
    else if (frame_state == PARITY && fall)    par_bit <= dbit;
  end
  assign par_ok = ^{shift, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    frame_next = frame_state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    tcnt_n     = '0;
    good       = 1'b0;
    ferr       = 1'b0;
    case (frame_state)
      IDLE: if (fall && !dbit) begin
        frame_next = DATA;
        bit_cnt_n  = '0;
      end
      DATA: if (fall) begin
        shift_n   = {dbit, shift[7:1]};
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) frame_next = PARITY;
      end
      PARITY: if (fall) frame_next = STOP;
      STOP: if (fall) begin
        frame_next = IDLE;
        if (dbit && par_ok) good = 1'b1;
        else                ferr = 1'b1;
      end
      default: frame_next = IDLE;
    endcase
    if (frame_state != IDLE && !fall) begin
      if (tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
        ferr       = 1'b1;
        frame_next = IDLE;
      end else begin
        tcnt_n = tcnt + TCW'(1);
      end
    end
  end

  // Stage 2: frame result registered (byte/byte_vld/err one cycle after the STOP edge)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_state <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      tcnt        <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      frame_state <= frame_next;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      tcnt        <= tcnt_n;
      byte_vld_q  <= good;
      err_q       <= ferr;
      if (good) byte_q <= shift;
    end
  end

  // Decode FSM: E0/F0 prefixes, then match {ext, code} against the key table
  typedef enum logic [1:0] {BASE, EXT, BRK, EXT_BRK} dec_t;
  dec_t                dec_state, dec_next;
  logic [NUM_KEYS-1:0] held_q, press_q, rel_q;
  logic [NUM_KEYS-1:0] held_n, press_n, rel_n;
  logic                is_ext, is_brk, ignored;

  always_comb begin
    dec_next = dec_state;
    held_n   = held_q;
    press_n  = '0;
    rel_n    = '0;
    is_ext   = (dec_state == EXT) || (dec_state == EXT_BRK);
    is_brk   = (dec_state == BRK) || (dec_state == EXT_BRK);
    ignored  = byte_q inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1};
    if (err_q) begin
      dec_next = BASE;
    end else if (byte_vld_q) begin
      if (byte_q == 8'hE0 && dec_state == BASE)      dec_next = EXT;
      else if (byte_q == 8'hF0 && dec_state == BASE) dec_next = BRK;
      else if (byte_q == 8'hF0 && dec_state == EXT)  dec_next = EXT_BRK;
      else begin
        dec_next = BASE;
        if (!ignored) begin
          for (int i = 0; i < NUM_KEYS; i++) begin
            if (KEY_CODES[9*i +: 9] == {is_ext, byte_q}) begin
              if (is_brk) begin
                rel_n[i]  = held_q[i];
                held_n[i] = 1'b0;
              end else begin
                press_n[i] = ~held_q[i];
                held_n[i]  = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Stage 3: key state registered (two cycles after the STOP edge)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_state <= BASE;
      held_q    <= '0;
      press_q   <= '0;
      rel_q     <= '0;
    end else begin
      dec_state <= dec_next;
      held_q    <= held_n;
      press_q   <= press_n;
      rel_q     <= rel_n;
    end
  end

  assign keyboard_keymap_held     = held_q;
  assign keyboard_keymap_press    = press_q;
  assign keyboard_keymap_release  = rel_q;
  assign keyboard_keymap_byte     = byte_q;
  assign keyboard_keymap_byte_vld = byte_vld_q;
  assign keyboard_keymap_err      = err_q;

endmodule
